hera_mem_arbiter: RTL and testbench
===================================

# hera_mem_arbiter

Two-port arbiter that shares the single-port 4K x 16 data RAM between the HERA core execute stage and an external loader/debug port. The core's load/store/call/return accesses normally win. The external port is served in idle cycles, and a bounded starvation counter forces it through when the core keeps the RAM busy. The block sits between the core's RAM request signals, the external port, and the RAM macro. It returns read data with one-cycle latency, and it raises a stall toward the core when the core loses a cycle.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 16, RAM data width
- STARVE_MAX, 4, consecutive denied external cycles before external wins; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access issued to RAM this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid (cycle after granted read)
- core_rdata  out  DATA_W  core read data; 0 when core_rvalid=0
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external request, same rules as core
- ext_gnt  out  1  external access issued this cycle
- ext_rvalid  out  1  external read data valid
- ext_rdata  out  DATA_W  external read data; 0 when ext_rvalid=0
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read strobe

## Operation
- Requesters must hold req, we, addr and wdata stable until the cycle their gnt is high. Accepting in the gnt cycle completes the handshake.
- Arbitration is combinational from current requests and registered starve_cnt. Width of starve_cnt is 4 bits, saturating.
  - ext_win = ext_req & (~core_req | starve_cnt == STARVE_MAX).
  - core_gnt = core_req & ~ext_win; ext_gnt = ext_win.
  - At most one gnt is high per cycle.
- RAM drive:
  - mem_en = core_gnt | ext_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the winner.
  - All mem_* are 0 when mem_en=0.
- starve_cnt update:
  - cleared when ext_gnt=1 or ext_req=0;
  - otherwise incremented, saturating at STARVE_MAX.
- Read return tracking uses two registered flags, rd_core and rd_ext:
  - rd_core <= core_gnt & ~core_we; rd_ext <= ext_gnt & ~ext_we.
  - core_rvalid = rd_core; ext_rvalid = rd_ext.
  - rdata = mem_rdata when the matching rvalid is high, else 0.
- Writes produce no rvalid.
- No read-after-write forwarding: RAM ordering applies. Back-to-back accesses are allowed every cycle.

## Timing
- Reset (rst=0 at a clk edge):
  - starve_cnt=0, rd_core=0, rd_ext=0.
  - While rst=0, all gnt, stall, mem_en, mem_we and rvalid are forced to 0, and mem_addr, mem_wdata and rdata are 0.
- Grant latency: 0 cycles, since gnt and mem_* assert combinationally in the request cycle.
- Read latency: 1 cycle from gnt to rvalid and rdata.
- Worst-case external wait under continuous core traffic: STARVE_MAX denied cycles, then granted on cycle STARVE_MAX+1.
- Worst-case core penalty: 1 stall cycle per forced external grant.
- Simultaneous requests with starve_cnt < STARVE_MAX: core wins, ext denied, starve_cnt increments.
- ext_req dropped before grant (protocol violation tolerated): starve_cnt clears, no access occurs.
- Reset asserted while a read is in flight: the pending rvalid is killed; no rvalid appears after reset.

## Test plan
- Reset: hold rst=0 for 3 cycles with both req=1 -> all gnt=0, mem_en=0, rvalid=0. Release -> core_gnt=1 in the same cycle.
- Core read: RAM[0x010]=0xBEEF; core_req, we=0, addr=0x010 -> cycle 0: core_gnt=1, mem_en=1, mem_we=0. Cycle 1: core_rvalid=1, core_rdata=0xBEEF, ext_rvalid=0.
- Idle external write: core_req=0; ext writes 0x1234 to 0xFFF -> ext_gnt=1, mem_we=1, mem_addr=0xFFF. Then a core read of 0xFFF returns 0x1234 one cycle after its grant.
- Starvation: core_req=1 every cycle and ext_req=1 from cycle 0, STARVE_MAX=4:
  - cycles 0-3: core_gnt=1;
  - cycle 4: ext_gnt=1, core_stall=1;
  - cycle 5: core_gnt=1 and starve_cnt=0.
- Back-to-back mixed traffic: alternate core read 0x001 and ext read 0x002 on consecutive cycles -> each rvalid asserts only on its own port, one cycle after its grant, with the correct data and no cross-port leakage.
- Reset mid-read: core read granted at cycle N with rst=0 at cycle N+1 -> core_rvalid=0 at N+1 and afterwards. After release, starve_cnt=0.

Source files
------------

// File: rtl/hera_mem_arbiter.sv
// rtl/hera_mem_arbiter.sv - core/external arbiter for the shared single-port data RAM
// Core wins by default; a saturating starvation counter forces the external port through.
module hera_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       rd_core;
  logic       rd_ext;
  logic       ext_win;

  // rst gates every output so nothing leaks while reset is held, including in-flight reads
  assign ext_win     = rst & ext_req & (~core_req | (starve_cnt == SMAX));
  assign ext_gnt     = ext_win;
  assign core_gnt    = rst & core_req & ~ext_win;
  assign core_stall  = rst & core_req & ~core_gnt;
  assign mem_en      = core_gnt | ext_gnt;

  assign core_rvalid = rst & rd_core;
  assign ext_rvalid  = rst & rd_ext;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ext_rdata   = ext_rvalid ? mem_rdata : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      rd_core    <= 1'b0;
      rd_ext     <= 1'b0;
    end else begin
      rd_core <= core_gnt & ~core_we;
      rd_ext  <= ext_gnt & ~ext_we;
      if (ext_gnt || !ext_req)
        starve_cnt <= '0;
      else if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_hera_mem_arbiter.sv
// tb/tb_hera_mem_arbiter.sv - directed self-checking bench for hera_mem_arbiter
// Behavioural 4K x 16 RAM with one-cycle read latency sits on the mem_* side.
module tb_hera_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, ext_req, ext_we;
  logic [11:0] core_addr, ext_addr;
  logic [15:0] core_wdata, ext_wdata;
  logic        core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid;
  logic [15:0] core_rdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] ram [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  hera_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the active edge; checks happen mid-cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [15:0] cd,
                       input logic er, input logic ew, input logic [11:0] ea, input logic [15:0] ed);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ext_req  = er; ext_we  = ew; ext_addr  = ea; ext_wdata  = ed;
    #4;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
    ram[12'h010] = 16'hBEEF;
    ram[12'h001] = 16'hAAAA;
    ram[12'h002] = 16'h5555;
    ram[12'h003] = 16'h0C0C;

    // reset held with both ports requesting
    rst = 1'b0;
    drive(1, 0, 12'h010, 16'h0, 1, 0, 12'h002, 16'h0);
    for (int c = 0; c < 3; c++) begin
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_ext_gnt", ext_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_rvalid", {core_rvalid, ext_rvalid}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      tick();
    end

    // release: core wins in the same cycle, a read of 0x010
    rst = 1'b1;
    drive(1, 0, 12'h010, 16'h0, 1, 0, 12'h002, 16'h0);
    chk("rel_core_gnt", core_gnt, 1);
    chk("rel_ext_gnt", ext_gnt, 0);
    chk("rel_stall", core_stall, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 12'h010);

    // ext dropped before grant: no access, counter clears
    tick();
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("rd_core_rvalid", core_rvalid, 1);
    chk("rd_core_rdata", core_rdata, 16'hBEEF);
    chk("rd_ext_rvalid", ext_rvalid, 0);
    chk("rd_ext_rdata", ext_rdata, 0);
    chk("idle_mem_en", mem_en, 0);

    // idle external write to 0xFFF
    tick();
    drive(0, 0, 12'h0, 16'h0, 1, 1, 12'hFFF, 16'h1234);
    chk("drop_starve_cnt", dut.starve_cnt, 0);
    chk("ew_ext_gnt", ext_gnt, 1);
    chk("ew_core_gnt", core_gnt, 0);
    chk("ew_mem_we", mem_we, 1);
    chk("ew_mem_addr", mem_addr, 12'hFFF);
    chk("ew_mem_wdata", mem_wdata, 16'h1234);

    tick();
    drive(1, 0, 12'hFFF, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("ew_no_rvalid", ext_rvalid, 0);
    chk("rb_core_gnt", core_gnt, 1);
    tick();
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("rb_core_rvalid", core_rvalid, 1);
    chk("rb_core_rdata", core_rdata, 16'h1234);

    // starvation under continuous core reads
    for (int k = 0; k < 6; k++) begin
      tick();
      drive(1, 0, 12'h003, 16'h0, 1, 0, 12'h002, 16'h0);
      chk("sv_starve_cnt", dut.starve_cnt, (k == 5) ? 0 : k);
      chk("sv_core_gnt", core_gnt, (k == 4) ? 0 : 1);
      chk("sv_ext_gnt", ext_gnt, (k == 4) ? 1 : 0);
      chk("sv_stall", core_stall, (k == 4) ? 1 : 0);
      chk("sv_ext_rvalid", ext_rvalid, (k == 5) ? 1 : 0);
      if (k == 4) chk("sv_mem_addr", mem_addr, 12'h002);
      if (k == 5) chk("sv_ext_rdata", ext_rdata, 16'h5555);
    end

    // back-to-back alternating reads, no cross-port leakage
    tick();
    drive(1, 0, 12'h001, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("bb0_core_gnt", core_gnt, 1);
    chk("bb0_core_rdata", core_rdata, 16'h0C0C);
    tick();
    drive(0, 0, 12'h0, 16'h0, 1, 0, 12'h002, 16'h0);
    chk("bb1_ext_gnt", ext_gnt, 1);
    chk("bb1_core_rvalid", core_rvalid, 1);
    chk("bb1_core_rdata", core_rdata, 16'hAAAA);
    chk("bb1_ext_rvalid", ext_rvalid, 0);
    chk("bb1_ext_rdata", ext_rdata, 0);
    tick();
    drive(1, 0, 12'h001, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("bb2_core_gnt", core_gnt, 1);
    chk("bb2_ext_rvalid", ext_rvalid, 1);
    chk("bb2_ext_rdata", ext_rdata, 16'h5555);
    chk("bb2_core_rvalid", core_rvalid, 0);
    chk("bb2_core_rdata", core_rdata, 0);
    tick();
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("bb3_core_rvalid", core_rvalid, 1);
    chk("bb3_core_rdata", core_rdata, 16'hAAAA);
    chk("bb3_ext_rvalid", ext_rvalid, 0);

    // reset mid-read: pending rvalid is killed, counter cleared
    tick();
    drive(1, 0, 12'h010, 16'h0, 1, 0, 12'h002, 16'h0);
    chk("mr_core_gnt", core_gnt, 1);
    tick();
    rst = 1'b0;
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("mr_rvalid_in_rst", core_rvalid, 0);
    chk("mr_rdata_in_rst", core_rdata, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    chk("mr_rvalid_after", core_rvalid, 0);
    chk("mr_starve_cnt", dut.starve_cnt, 0);
    tick();
    chk("mr_rvalid_later", core_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
